// File: rtl/q_pkg.sv
// Shared definitions for the Q-table max-scan block: widths, the
// "no action" marker and the scan FSM state encoding.
package q_pkg;

    localparam int QW    = 16;
    localparam int N_ACT = 9;
    localparam int SW    = 15;
    localparam int AW    = 4;

    localparam logic [AW-1:0] ACT_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/q_cmp_sel.sv
// Combinational signed compare-select for the running maximum.
// A candidate wins when it is the first legal value seen or strictly
// greater than the current maximum, so ties keep the earlier (lower) action.
module q_cmp_sel #(
    parameter int QW = 16
) (
    input  logic [QW-1:0] cand,
    input  logic [QW-1:0] cur,
    input  logic          first,
    output logic [QW-1:0] new_max,
    output logic          take
);

    // Full-width signed comparison, no saturation.
    always_comb begin
        take    = first || ($signed(cand) > $signed(cur));
        new_max = take ? cand : cur;
    end

endmodule

// File: rtl/q_max_scan.sv
// Scans the Q-table row of one state and returns max_a Q(s',a) over the
// legal actions together with the argmax. Reads are issued one action per
// cycle; the returned data is compared one cycle later, and the result is
// held until the downstream updater accepts it.
module q_max_scan
    import q_pkg::*;
#(
    parameter int QW    = q_pkg::QW,
    parameter int N_ACT = q_pkg::N_ACT,
    parameter int SW    = q_pkg::SW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    state_idx,
    input  logic [N_ACT-1:0] legal_mask,
    output logic             rd_en,
    output logic [SW-1:0]    rd_state,
    output logic [3:0]       rd_action,
    input  logic [QW-1:0]    rd_data,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    max_q,
    output logic [3:0]       best_action,
    output logic             no_legal
);

    localparam logic [3:0] LAST_ACT = 4'(N_ACT - 1);

    scan_state_t      state_q,      state_d;
    logic             busy_q,       busy_d;
    logic             out_valid_q,  out_valid_d;
    logic             rd_en_q,      rd_en_d;
    logic [SW-1:0]    rd_state_q,   rd_state_d;
    logic [3:0]       rd_action_q,  rd_action_d;
    logic [N_ACT-1:0] mask_q,       mask_d;
    logic             cmp_valid_q,  cmp_valid_d;
    logic [3:0]       cmp_act_q,    cmp_act_d;
    logic [QW-1:0]    max_q_q,      max_q_d;
    logic [3:0]       best_q,       best_d;
    logic             have_q,       have_d;
    logic             no_legal_q,   no_legal_d;

    logic [QW-1:0]    sel_max;
    logic             sel_take;

    q_cmp_sel #(
        .QW(QW)
    ) u_cmp_sel (
        .cand    (rd_data),
        .cur     (max_q_q),
        .first   (~have_q),
        .new_max (sel_max),
        .take    (sel_take)
    );

    // Next-state logic: read sequencing, compare stage and output handshake.
    always_comb begin
        logic [3:0]       next_act;
        logic [N_ACT-1:0] mask_shift;

        state_d     = state_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        rd_en_d     = 1'b0;
        rd_state_d  = rd_state_q;
        rd_action_d = rd_action_q;
        mask_d      = mask_q;
        max_q_d     = max_q_q;
        best_d      = best_q;
        have_d      = have_q;
        no_legal_d  = no_legal_q;
        next_act    = rd_action_q + 4'd1;
        mask_shift  = mask_q >> next_act;

        // The read issued last cycle returns its data now.
        cmp_valid_d = rd_en_q;
        cmp_act_d   = rd_action_q;

        if (cmp_valid_q && sel_take) begin
            max_q_d = sel_max;
            best_d  = cmp_act_q;
            have_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SCAN;
                    busy_d      = 1'b1;
                    rd_state_d  = state_idx;
                    mask_d      = legal_mask;
                    rd_action_d = 4'd0;
                    rd_en_d     = legal_mask[0];
                    max_q_d     = '0;
                    best_d      = ACT_NONE;
                    have_d      = 1'b0;
                    no_legal_d  = (legal_mask == '0);
                end
            end
            SCAN: begin
                if (rd_action_q == LAST_ACT) begin
                    state_d     = DRAIN;
                    rd_action_d = 4'd0;
                end else begin
                    rd_action_d = next_act;
                    rd_en_d     = mask_shift[0];
                end
            end
            DRAIN: begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_state_q  <= '0;
            rd_action_q <= 4'd0;
            mask_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_act_q   <= 4'd0;
            max_q_q     <= '0;
            best_q      <= ACT_NONE;
            have_q      <= 1'b0;
            no_legal_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rd_en_q     <= rd_en_d;
            rd_state_q  <= rd_state_d;
            rd_action_q <= rd_action_d;
            mask_q      <= mask_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_act_q   <= cmp_act_d;
            max_q_q     <= max_q_d;
            best_q      <= best_d;
            have_q      <= have_d;
            no_legal_q  <= no_legal_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_state    = rd_state_q;
    assign rd_action   = rd_action_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign max_q       = max_q_q;
    assign best_action = best_q;
    assign no_legal    = no_legal_q;

endmodule

// File: tb/tb_q_max_scan.sv
// Testbench for q_max_scan: directed scenarios plus randomized scans
// checked against a behavioural max/argmax model of the Q-table row.
module tb_q_max_scan;
    import q_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [SW-1:0]    state_idx;
    logic [N_ACT-1:0] legal_mask;
    logic             rd_en;
    logic [SW-1:0]    rd_state;
    logic [3:0]       rd_action;
    logic [QW-1:0]    rd_data;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [QW-1:0]    max_q;
    logic [3:0]       best_action;
    logic             no_legal;

    int qtab [N_ACT];
    int checks = 0;
    int passed = 0;

    q_max_scan dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_idx   (state_idx),
        .legal_mask  (legal_mask),
        .rd_en       (rd_en),
        .rd_state    (rd_state),
        .rd_action   (rd_action),
        .rd_data     (rd_data),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .max_q       (max_q),
        .best_action (best_action),
        .no_legal    (no_legal)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Q-table model: data valid one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (rd_en && rd_action < 4'(N_ACT))
            rd_data <= QW'(qtab[rd_action]);
        else
            rd_data <= QW'($urandom);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: maximum over legal entries, argmax is the lowest index holding it.
    function automatic void model(input logic [N_ACT-1:0] m, output int mx,
                                  output int ba, output bit nl);
        bit found;
        nl = (m == '0);
        mx = 0;
        ba = 15;
        found = 1'b0;
        for (int a = 0; a < N_ACT; a++)
            if (m[a] && (!found || qtab[a] > mx)) begin
                mx = qtab[a];
                found = 1'b1;
            end
        for (int a = N_ACT - 1; a >= 0; a--)
            if (m[a] && qtab[a] == mx) ba = a;
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"},      int'(busy),        0);
        checkOutput({tag, "_out_valid"}, int'(out_valid),   0);
        checkOutput({tag, "_rd_en"},     int'(rd_en),       0);
        checkOutput({tag, "_rd_state"},  int'(rd_state),    0);
        checkOutput({tag, "_rd_action"}, int'(rd_action),   0);
        checkOutput({tag, "_max_q"},     int'($signed(max_q)), 0);
        checkOutput({tag, "_best"},      int'(best_action), 15);
        checkOutput({tag, "_no_legal"},  int'(no_legal),    0);
    endtask

    // Issue one scan, follow it to out_valid and compare the result with the model.
    task automatic applyStimulus(input logic [SW-1:0] idx, input logic [N_ACT-1:0] mask,
                                 input bit early);
        int cyc, pulses, emx, eba;
        bit enl, seen;
        model(mask, emx, eba, enl);
        state_idx  = idx;
        legal_mask = mask;
        start      = 1'b1;
        out_ready  = early;
        cyc = 0;
        pulses = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            step();
            start      = 1'b0;
            legal_mask = N_ACT'($urandom);
            state_idx  = SW'($urandom);
            cyc++;
            if (cyc == 1) checkOutput("busy_on", int'(busy), 1);
            if (cyc <= N_ACT) begin
                checkOutput("rd_action", int'(rd_action), cyc - 1);
                checkOutput("rd_en_mask", int'(rd_en), int'(mask[cyc-1]));
            end else begin
                checkOutput("rd_en_quiet", int'(rd_en), 0);
            end
            if (rd_en) begin
                pulses++;
                checkOutput("rd_state", int'(rd_state), int'(idx));
            end
            if (out_valid) seen = 1'b1;
        end
        checkOutput("latency", seen ? cyc : -1, N_ACT + 2);
        checkOutput("rd_en_pulses", pulses, $countones(mask));
        checkOutput("max_q", int'($signed(max_q)), emx);
        checkOutput("best_action", int'(best_action), eba);
        checkOutput("no_legal", int'(no_legal), int'(enl));
        checkOutput("busy_hold", int'(busy), 1);
    endtask

    // Complete the output handshake and confirm the block returns to idle.
    task automatic finishTransfer(input bit start_during);
        out_ready = 1'b1;
        start     = start_during;
        step();
        checkOutput("xfer_out_valid", int'(out_valid), 0);
        checkOutput("xfer_busy", int'(busy), 0);
        out_ready = 1'b0;
        start     = 1'b0;
        step();
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        int emx, eba;
        bit enl;
        logic [N_ACT-1:0] m;
        $display("[TB] q_max_scan bench start");
        rst        = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b0;
        state_idx  = '0;
        legal_mask = '0;
        for (int a = 0; a < N_ACT; a++) qtab[a] = 0;
        step();
        step();
        checkReset("reset");
        rst = 1'b0;

        // Full mask with a tie at the maximum.
        qtab = '{5, -3, 12, 12, 0, 7, -8, 1, 2};
        applyStimulus(15'd1234, 9'h1FF, 1'b0);
        checkOutput("dir1_max", int'($signed(max_q)), 12);
        checkOutput("dir1_best", int'(best_action), 2);
        finishTransfer(1'b0);

        // Terminal state: no legal actions.
        applyStimulus(15'd19682, 9'h000, 1'b0);
        checkOutput("dir2_best", int'(best_action), 15);
        checkOutput("dir2_no_legal", int'(no_legal), 1);
        finishTransfer(1'b0);

        // Only negative legal values; illegal entries are larger.
        for (int a = 0; a < N_ACT; a++) qtab[a] = 32767;
        qtab[5] = -200;
        qtab[7] = -100;
        applyStimulus(15'd77, 9'h0A0, 1'b0);
        checkOutput("dir3_max", int'($signed(max_q)), -100);
        checkOutput("dir3_best", int'(best_action), 7);
        finishTransfer(1'b0);

        // Stall in HOLD while start pulses; outputs must not move.
        for (int a = 0; a < N_ACT; a++) qtab[a] = int'($urandom_range(0, 65535)) - 32768;
        model(9'h1FF, emx, eba, enl);
        applyStimulus(15'd4242, 9'h1FF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start      = i[0];
            legal_mask = N_ACT'($urandom);
            step();
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_busy", int'(busy), 1);
            checkOutput("stall_rd_en", int'(rd_en), 0);
            checkOutput("stall_max", int'($signed(max_q)), emx);
            checkOutput("stall_best", int'(best_action), eba);
            checkOutput("stall_no_legal", int'(no_legal), 0);
        end
        finishTransfer(1'b1);

        // Reset in the middle of a scan, then an immediate new scan.
        for (int a = 0; a < N_ACT; a++) qtab[a] = 32767;
        state_idx  = 15'd999;
        legal_mask = 9'h1FF;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checkOutput("mid_rd_action", int'(rd_action), 4);
        rst = 1'b1;
        step();
        checkReset("midrst");
        step();
        checkReset("midrst_hold");
        rst = 1'b0;
        qtab[0] = 9;
        applyStimulus(15'd5, 9'h001, 1'b0);
        checkOutput("post_rst_max", int'($signed(max_q)), 9);
        checkOutput("post_rst_best", int'(best_action), 0);
        finishTransfer(1'b0);

        // Randomized scans, mixing narrow value ranges (ties) and full range.
        for (int n = 0; n < 24; n++) begin
            for (int a = 0; a < N_ACT; a++)
                if (n[0]) qtab[a] = int'($urandom_range(0, 6)) - 3;
                else      qtab[a] = int'($urandom_range(0, 65535)) - 32768;
            m = N_ACT'($urandom);
            if (n == 5) m = '0;
            applyStimulus(SW'($urandom), m, 1'($urandom_range(0, 1)));
            finishTransfer(1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/q_max_scan.md
Q_MAX_SCAN -- requirements
Module: q_max_scan

Interface
REQ-001 Parameter QW, default 16: Q-value width, two's-complement signed.
REQ-002 Parameter N_ACT, default 9: actions (board cells) per state.
REQ-003 Parameter SW, default 15: state-index width (3^9 = 19683 states).
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  scan request; sampled only in IDLE.
REQ-007 state_idx  in  SW  next-state index; latched when start is accepted.
REQ-008 legal_mask  in  N_ACT  bit a=1 means action a (empty cell) is legal; latched with state_idx.
REQ-009 rd_en  out  1  Q-table read strobe.
REQ-010 rd_state  out  SW  read address, state part.
REQ-011 rd_action  out  4  read address, action part.
REQ-012 rd_data  in  QW  Q-table data, valid exactly 1 cycle after rd_en.
REQ-013 busy  out  1  high from start acceptance until the output transfer completes.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  downstream Q-updater accepts the result.
REQ-016 max_q  out  QW  maximum legal Q(s',a), fed to the updater's max_Q.
REQ-017 best_action  out  4  argmax action; 4'hF if no legal action.
REQ-018 no_legal  out  1  legal_mask was all-zero (terminal state).

Function
REQ-019 FSM states: IDLE, SCAN, DRAIN, HOLD.
REQ-020 IDLE: when start=1, latch state_idx and legal_mask, clear the accumulator and go to SCAN; otherwise stay in IDLE.
REQ-021 SCAN: lasts N_ACT cycles with action counter a = 0..N_ACT-1; each cycle drive rd_action=a and rd_state=latched index; rd_en=legal_mask[a]; after a=N_ACT-1 go to DRAIN.
REQ-022 Compare stage: one cycle after each rd_en, rd_data is compared (signed) against the accumulator; it replaces max_q/best_action if it is the first legal value or strictly greater than the accumulator.
REQ-023 Ties keep the lowest action index; illegal actions never affect the result.
REQ-024 DRAIN: a single cycle that compares the last read; then go to HOLD.
REQ-025 HOLD: out_valid=1; max_q, best_action and no_legal stay stable until out_valid & out_ready; on transfer go to IDLE with out_valid=0 the next cycle.
REQ-026 Latency: start sampled in cycle t, out_valid asserted in cycle t+N_ACT+2 (t+11 by default), independent of the mask.
REQ-027 All-zero mask: rd_en never asserts; result is max_q=0, best_action=4'hF, no_legal=1.
REQ-028 start is ignored outside IDLE, including the transfer cycle; no queueing.
REQ-029 out_ready high before out_valid is legal and causes a transfer in the first HOLD cycle.
REQ-030 The comparison is full-width signed; no saturation or truncation.
REQ-031 rd_en=0 in IDLE, DRAIN and HOLD.

Reset
REQ-032 When rst=1: state becomes IDLE; busy=0, out_valid=0, rd_en=0, rd_state=0, rd_action=0, max_q=0, best_action=4'hF, no_legal=0; all of these hold next cycle.
REQ-033 Reset mid-SCAN or mid-HOLD abandons the scan; rd_data arriving after reset is ignored.
REQ-034 After reset, start is accepted in the first cycle with rst=0.

Structure
REQ-035 Shared package q_pkg holds: QW, N_ACT, SW, ACT_NONE=4'hF, and the scan FSM state enum.
REQ-036 One sub-module q_cmp_sel: combinational signed compare-select (candidate, current, first-flag) returning the new max and a take flag.

Verification
REQ-037 Mask 9'h1FF, Q = {5,-3,12,12,0,7,-8,1,2} -> max_q=12, best_action=2, no_legal=0, out_valid at t+11.
REQ-038 Mask 9'h000 -> rd_en never high, max_q=0, best_action=4'hF, no_legal=1, out_valid at t+11.
REQ-039 Mask 9'h0A0 (actions 5,7), Q5=-200, Q7=-100, others 32767 -> max_q=-100, best_action=7, exactly 2 rd_en pulses.
REQ-040 out_ready low for 20 cycles in HOLD while start pulses -> outputs stable, start ignored, a single transfer when ready rises, IDLE next cycle.
REQ-041 rst pulsed in SCAN at a=4, then a new start with mask 9'h001 and Q0=9 -> all outputs at reset values, then max_q=9, best_action=0.
